// File: rtl/axi_cfg_rd_bridge.sv
// axi_cfg_rd_bridge: AXI4 read slave that turns one burst at a time into rd/raddr strobes with a credit-limited return FIFO
module axi_cfg_rd_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  rd,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  rvalid
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] ONE = 1;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_nx;
    logic                  ready_q, err_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q, issued, returned;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [CW-1:0]         outstanding, count;
    logic [PW-1:0]         wptr, rptr;
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [1:0]            mem_resp [FIFO_DEPTH];
    logic                  mem_last [FIFO_DEPTH];
    logic ar_hs, credit, go, ret_push, err_push, push, pop, last_hs, wrap_len_ok, ar_err;
    logic [ADDR_WIDTH-1:0] ar_span, ar_mask, ar_end, step, wrap_mask, addr_inc, addr_nx;
    assign s_axi_arready = ready_q;
    assign ar_hs = s_axi_arvalid & ready_q;
    // credit counts both in-flight reads and queued beats, so a full FIFO can never be overrun
    assign credit = ({1'b0, outstanding} + {1'b0, count}) < (CW + 1)'(FIFO_DEPTH);
    assign go = (state == ISSUE) & credit;
    assign rd = go & ~err_q;
    assign raddr = addr_q;
    assign ret_push = rvalid & (outstanding != '0);
    assign err_push = go & err_q;
    assign push = ret_push | err_push;
    assign s_axi_rvalid = count != '0;
    assign pop = s_axi_rvalid & s_axi_rready;
    assign last_hs = pop & mem_last[rptr];
    assign s_axi_rid = id_q;
    assign s_axi_rdata = s_axi_rvalid ? mem_data[rptr] : '0;
    assign s_axi_rresp = s_axi_rvalid ? mem_resp[rptr] : 2'b00;
    assign s_axi_rlast = s_axi_rvalid & mem_last[rptr];
    always_comb begin
        ar_span = ADDR_WIDTH'(s_axi_arlen) << s_axi_arsize;
        ar_mask = ((ADDR_WIDTH'(s_axi_arlen) + ONE) << s_axi_arsize) - ONE;
        ar_end = s_axi_arburst == 2'd0 ? s_axi_araddr :
                 s_axi_arburst == 2'd2 ? (s_axi_araddr & ~ar_mask) + ar_span : s_axi_araddr + ar_span;
        wrap_len_ok = s_axi_arlen == 8'd1 || s_axi_arlen == 8'd3 || s_axi_arlen == 8'd7 || s_axi_arlen == 8'd15;
        ar_err = s_axi_arsize > MAX_SIZE || s_axi_arburst == 2'd3 || (s_axi_arburst == 2'd2 && !wrap_len_ok) ||
                 s_axi_araddr > ADDR_LIMIT || ar_end > ADDR_LIMIT;
    end
    always_comb begin
        step = ONE << size_q;
        wrap_mask = ((ADDR_WIDTH'(len_q) + ONE) << size_q) - ONE;
        addr_inc = addr_q + step;
        addr_nx = burst_q == 2'd0 ? addr_q :
                  burst_q == 2'd2 ? (addr_q & ~wrap_mask) | (addr_inc & wrap_mask) : addr_inc;
    end
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE && ar_hs) ? ISSUE :
                   (state == ISSUE && go && issued == len_q) ? DRAIN :
                   (state == DRAIN && last_hs) ? IDLE : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ready_q <= 1'b0;
            err_q <= 1'b0;
            id_q <= '0;
            addr_q <= '0;
            len_q <= '0;
            size_q <= '0;
            burst_q <= '0;
            issued <= '0;
            returned <= '0;
            outstanding <= '0;
            count <= '0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            state <= state_nx;
            ready_q <= state_nx == IDLE;
            if (ar_hs) begin
                id_q <= s_axi_arid;
                addr_q <= s_axi_araddr;
                len_q <= s_axi_arlen;
                size_q <= s_axi_arsize;
                burst_q <= s_axi_arburst;
                err_q <= ar_err;
                issued <= '0;
                returned <= '0;
            end else begin
                if (go) begin
                    issued <= issued + 8'd1;
                    addr_q <= addr_nx;
                end
                if (push) returned <= returned + 8'd1;
            end
            outstanding <= outstanding + CW'(rd) - CW'(ret_push);
            count <= count + CW'(push) - CW'(pop);
            if (push) wptr <= wptr + PW'(1);
            if (pop) rptr <= rptr + PW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wptr] <= ret_push ? rdata : '0;
            mem_resp[wptr] <= err_push ? 2'b10 : 2'b00;
            mem_last[wptr] <= returned == len_q;
        end
    end
endmodule

// File: tb/tb_axi_cfg_rd_bridge.sv
// tb_axi_cfg_rd_bridge: random-latency memory and random R backpressure against a burst-level reference model
module tb_axi_cfg_rd_bridge;
    localparam logic [31:0] LIMIT = 32'h0000_0FFF;
    localparam int DEPTH = 4;
    typedef struct {int due; logic [31:0] a;} req_t;
    typedef struct {logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic last;} beat_t;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] s_axi_arid = '0, s_axi_rid, s_axi_arlen = '0;
    logic [31:0] s_axi_araddr = '0, s_axi_rdata, raddr, mem_rdata = '0;
    logic [2:0] s_axi_arsize = '0;
    logic [1:0] s_axi_arburst = '0, s_axi_rresp;
    logic s_axi_arvalid = 1'b0, s_axi_arready, s_axi_rlast, s_axi_rvalid, s_axi_rready = 1'b0, rd, mem_rvalid = 1'b0;
    int total = 0, bad = 0, cyc = 0, lat_min = 0, lat_max = 0, rr_mode = 0, rr_until = 0;
    req_t pend[$];
    beat_t cap_q[$];
    logic [31:0] rd_q[$];

    axi_cfg_rd_bridge #(.ADDR_LIMIT(LIMIT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready), .rd(rd), .raddr(raddr), .rdata(mem_rdata), .rvalid(mem_rvalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0] + 16'h1234};
    endfunction

    // in-order memory: each rd returns no earlier than the following cycle
    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        mem_rdata = $urandom();
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata = mem_val(pend[0].a);
            void'(pend.pop_front());
        end
        if (rd === 1'b1) pend.push_back('{cyc + 1 + lat_min + int'($urandom_range(0, lat_max)), raddr});
    end

    always @(negedge clk) begin
        s_axi_rready = (cyc < rr_until) ? 1'b0 : (rr_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rd === 1'b1) rd_q.push_back(raddr);
        if (s_axi_rvalid === 1'b1 && s_axi_rready) cap_q.push_back('{s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_ar(input logic [7:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bt, output bit ok);
        int n = 0;
        @(negedge clk);
        s_axi_arid = id; s_axi_araddr = a; s_axi_arlen = len; s_axi_arsize = sz; s_axi_arburst = bt;
        s_axi_arvalid = 1'b1;
        while (s_axi_arready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = s_axi_arready === 1'b1;
        @(posedge clk);
        #1 s_axi_arvalid = 1'b0;
    endtask

    task automatic run_burst(input logic [7:0] id, input logic [31:0] a, input logic [7:0] len,
                             input logic [2:0] sz, input logic [1:0] bt, input int block, input string name);
        logic [31:0] exp_a[$];
        longint al, step, wb, base, x, maxa;
        bit err, ok;
        int nb, rb, cb, n, got_n, got_rd, exp_rd;
        logic [42:0] got, exp;
        al = longint'(a);
        step = longint'(1) << sz;
        nb = int'(len) + 1;
        wb = step * nb;
        base = al - (al % wb);
        maxa = 0;
        err = sz > 3'd2 || bt == 2'd3 || (bt == 2'd2 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
        for (int i = 0; i < nb; i++) begin
            x = bt == 2'd0 ? al : bt == 2'd1 ? (al + i * step) & 64'hFFFF_FFFF : base + ((al - base) + i * step) % wb;
            exp_a.push_back(32'(x));
            if (x > maxa) maxa = x;
        end
        if (maxa > longint'(LIMIT)) err = 1'b1;
        rb = rd_q.size();
        cb = cap_q.size();
        rr_until = cyc + block;
        send_ar(id, a, len, sz, bt, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s ar_accept: arready=0 required 1", name);
            return;
        end
        if (block > 0 && !err) begin
            repeat (block - 5) @(negedge clk);
            exp_rd = nb < DEPTH ? nb : DEPTH;
            total++;
            if (rd_q.size() - rb != exp_rd) begin
                bad++;
                $display("FAIL %s credit_stall: rd count=%0d required %0d", name, rd_q.size() - rb, exp_rd);
            end
        end
        n = 0;
        while (cap_q.size() - cb < nb && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        got_n = cap_q.size() - cb;
        got_rd = rd_q.size() - rb;
        exp_rd = err ? 0 : nb;
        total++;
        if (got_n != nb) begin
            bad++;
            $display("FAIL %s beat_count: got %0d required %0d", name, got_n, nb);
        end
        total++;
        if (got_rd != exp_rd) begin
            bad++;
            $display("FAIL %s rd_count: got %0d required %0d", name, got_rd, exp_rd);
        end
        for (int i = 0; i < exp_rd && i < got_rd; i++) begin
            total++;
            if (rd_q[rb + i] !== exp_a[i]) begin
                bad++;
                $display("FAIL %s raddr%0d: got %h required %h", name, i, rd_q[rb + i], exp_a[i]);
            end
        end
        for (int i = 0; i < nb && i < got_n; i++) begin
            got = {cap_q[cb + i].id, cap_q[cb + i].data, cap_q[cb + i].resp, cap_q[cb + i].last};
            exp = {id, err ? 32'h0 : mem_val(exp_a[i]), err ? 2'b10 : 2'b00, 1'(i == nb - 1)};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s beat%0d id/data/resp/last: got %h required %h", name, i, got, exp);
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({s_axi_arready, s_axi_rvalid, rd, s_axi_rlast, s_axi_rresp, s_axi_rdata, s_axi_rid, raddr} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got ar=%b rv=%b rd=%b raddr=%h required all 0", s_axi_arready, s_axi_rvalid, rd, raddr);
        end
        rst = 1'b0;
        #1;
        total++;
        if (s_axi_arready !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_arready: got %b required 0", s_axi_arready);
        end
        @(negedge clk);
        total++;
        if (s_axi_arready !== 1'b1) begin
            bad++;
            $display("FAIL first_clk_arready: got %b required 1", s_axi_arready);
        end
    endtask

    task automatic test_single;
        lat_min = 0; lat_max = 0; rr_mode = 0;
        run_burst(8'h5A, 32'h40, 8'd0, 3'd2, 2'd1, 0, "single");
    endtask

    task automatic test_backpressure;
        lat_min = 0; lat_max = 2; rr_mode = 0;
        run_burst(8'h11, 32'h100, 8'd7, 3'd2, 2'd1, 20, "backpressure");
    endtask

    task automatic test_wrap_fixed;
        lat_min = 0; lat_max = 1; rr_mode = 0;
        run_burst(8'h22, 32'h1C, 8'd3, 3'd2, 2'd2, 0, "wrap");
        rr_mode = 1;
        run_burst(8'h33, 32'h20, 8'd3, 3'd2, 2'd0, 0, "fixed");
        run_burst(8'h34, 32'h3A, 8'd7, 3'd1, 2'd2, 0, "wrap_half");
    endtask

    task automatic test_errors;
        lat_min = 0; lat_max = 1; rr_mode = 1;
        run_burst(8'h41, 32'hFF8, 8'd3, 3'd2, 2'd1, 0, "err_limit");
        run_burst(8'h42, 32'hFF0, 8'd3, 3'd2, 2'd1, 0, "edge_limit_ok");
        run_burst(8'h43, 32'h0, 8'd3, 3'd3, 2'd1, 0, "err_size");
        run_burst(8'h44, 32'h0, 8'd3, 3'd2, 2'd3, 0, "err_burst3");
        run_burst(8'h45, 32'h10, 8'd2, 3'd2, 2'd2, 0, "err_wrap_len");
    endtask

    task automatic test_reset_mid_burst;
        bit ok;
        int n = 0, cb, rb;
        lat_min = 4; lat_max = 1; rr_mode = 0; rr_until = 0;
        cb = cap_q.size();
        send_ar(8'h77, 32'h200, 8'd7, 3'd2, 2'd1, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL midrst_ar_accept: arready=0 required 1");
        end
        while (cap_q.size() - cb < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({s_axi_arready, s_axi_rvalid, rd, s_axi_rlast, s_axi_rresp, s_axi_rdata, s_axi_rid, raddr} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs: got ar=%b rv=%b rd=%b rid=%h required all 0", s_axi_arready, s_axi_rvalid, rd, s_axi_rid);
        end
        @(negedge clk);
        rst = 1'b0;
        cb = cap_q.size();
        rb = rd_q.size();
        n = 0;
        while (pend.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        total++;
        if (cap_q.size() - cb != 0 || rd_q.size() - rb != 0 || s_axi_arready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_late_rvalid: beats=%0d rds=%0d arready=%b required 0 0 1",
                     cap_q.size() - cb, rd_q.size() - rb, s_axi_arready);
        end
        lat_min = 0;
        run_burst(8'h78, 32'h300, 8'd3, 3'd2, 2'd1, 0, "after_reset");
    endtask

    task automatic test_back_to_back;
        logic [7:0] wl [5] = '{8'd1, 8'd3, 8'd7, 8'd15, 8'd2};
        logic [2:0] sz;
        logic [1:0] bt;
        logic [7:0] len;
        logic [31:0] a;
        rr_mode = 1; lat_min = 0;
        for (int k = 0; k < 30; k++) begin
            lat_max = int'($urandom_range(0, 3));
            sz = $urandom_range(0, 9) == 0 ? 3'd3 : 3'($urandom_range(0, 2));
            bt = 2'($urandom_range(0, 3));
            len = bt == 2'd2 ? wl[$urandom_range(0, 4)] : 8'($urandom_range(0, 9));
            a = 32'($urandom_range(0, 32'h11FF)) & ~((32'd1 << sz) - 32'd1);
            run_burst(8'(k), a, len, sz, bt, 0, "random");
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_backpressure;
        test_wrap_fixed;
        test_errors;
        test_reset_mid_burst;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
